selector_n_sync_mmu: RTL

//  Clocked N-way token selector for the MMU control path: a clock-synchronous successor to the click-based selectors.

---
 rtl/mmu_sel_pkg.sv | 19 +
 rtl/sel_fifo_mmu.sv | 59 +++++
 rtl/selector_n_sync_mmu.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mmu_sel_pkg.sv
// Shared types and sizing helpers for the synchronous MMU token selector.
package mmu_sel_pkg;

    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_FIRE = 2'd1,
        SEL_WAIT = 2'd2
    } selState_t;

    // Width needed to hold an occupancy of 0..depth without wrapping.
    function automatic int unsigned cntWidth(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic int unsigned idxWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sel_fifo_mmu.sv
// Synchronous circular token buffer holding select vectors; registered count/full/empty.
module sel_fifo_mmu
    import mmu_sel_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             pushData,
    input  logic                         pop,
    output logic [WIDTH-1:0]             popData,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned IdxW = idxWidth(DEPTH);
    localparam int unsigned CntW = cntWidth(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IdxW-1:0]  wrPtr;
    logic [IdxW-1:0]  rdPtr;
    logic             doPush;
    logic             doPop;
    logic [CntW-1:0]  countNext;

    function automatic logic [IdxW-1:0] nextPtr(input logic [IdxW-1:0] p);
        return (p == IdxW'(DEPTH - 1)) ? '0 : p + IdxW'(1);
    endfunction

    assign doPush    = push & ~full;
    assign doPop     = pop & ~empty;
    assign countNext = count + CntW'(doPush) - CntW'(doPop);
    assign popData   = mem[rdPtr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            count <= countNext;
            full  <= (countNext == CntW'(DEPTH));
            empty <= (countNext == '0);
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/selector_n_sync_mmu.sv
// Clocked N-way multicast token selector with buffered drives and joined frees.
// Optional stall watchdog enabled by defining SEL_TIMEOUT_EN.
module selector_n_sync_mmu
    import mmu_sel_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DEPTH     = 2
`ifdef SEL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_drive,
    input  logic [NUM_PORTS-1:0]         i_select,
    output logic                         o_free,
    output logic [NUM_PORTS-1:0]         o_driveNext,
    input  logic [NUM_PORTS-1:0]         i_freeNext,
    output logic                         o_busy,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_err_overflow,
    output logic                         o_timeout
);

    localparam int unsigned CntW = cntWidth(DEPTH);

`ifdef SEL_TIMEOUT_EN
    localparam int unsigned WdW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WdW-1:0] wdog;
    logic [WdW-1:0] wdogNext;
    logic           abandon_c;
`endif

    selState_t            state;
    selState_t            stateNext;
    logic [NUM_PORTS-1:0] rSel;
    logic [NUM_PORTS-1:0] rSelNext;
    logic [NUM_PORTS-1:0] rPend;
    logic [NUM_PORTS-1:0] rPendNext;
    logic [NUM_PORTS-1:0] pendAfter_c;

    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [NUM_PORTS-1:0] fifoHead;
    logic [CntW-1:0]      fifoCount;

    logic                 accept_c;
    logic                 pushTok_c;
    logic                 drop_c;
    logic                 pop_c;
    logic                 complete_c;
    logic [CntW-1:0]      countNext_c;

    logic                 freeNext_c;
    logic [NUM_PORTS-1:0] driveNext_c;
    logic                 busyNext_c;
    logic                 errNext_c;
    logic                 timeoutNext_c;

    // Room is judged on the registered occupancy only; a same-cycle pop does not help.
    assign accept_c    = i_drive & ~fifoFull;
    assign pushTok_c   = accept_c & (|i_select);
    assign drop_c      = i_drive & fifoFull;
    assign pendAfter_c = rPend & ~i_freeNext;

    sel_fifo_mmu #(
        .WIDTH (NUM_PORTS),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (pushTok_c),
        .pushData (i_select),
        .pop      (pop_c),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    assign o_count = fifoCount;

    // State register with join and watchdog bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= SEL_IDLE;
            rSel  <= '0;
            rPend <= '0;
`ifdef SEL_TIMEOUT_EN
            wdog  <= '0;
`endif
        end else begin
            state <= stateNext;
            rSel  <= rSelNext;
            rPend <= rPendNext;
`ifdef SEL_TIMEOUT_EN
            wdog  <= wdogNext;
`endif
        end
    end

    // Next-state: pop on idle, join frees, chain straight into the next token on completion.
    always_comb begin
        stateNext  = state;
        rSelNext   = rSel;
        rPendNext  = rPend;
        pop_c      = 1'b0;
        complete_c = 1'b0;
`ifdef SEL_TIMEOUT_EN
        abandon_c  = 1'b0;
`endif
        case (state)
            SEL_IDLE: begin
                if (!fifoEmpty) begin
                    pop_c     = 1'b1;
                    rSelNext  = fifoHead;
                    rPendNext = fifoHead;
                    stateNext = SEL_FIRE;
                end
            end
            SEL_FIRE: begin
                rPendNext = pendAfter_c;
                if (pendAfter_c == '0) complete_c = 1'b1;
                else                   stateNext  = SEL_WAIT;
            end
            SEL_WAIT: begin
                rPendNext = pendAfter_c;
                if (pendAfter_c == '0) begin
                    complete_c = 1'b1;
`ifdef SEL_TIMEOUT_EN
                end else if (wdog == WdW'(TIMEOUT_CYC - 1)) begin
                    complete_c = 1'b1;
                    abandon_c  = 1'b1;
`endif
                end
            end
            default: stateNext = SEL_IDLE;
        endcase
        if (complete_c) begin
            if (!fifoEmpty) begin
                pop_c     = 1'b1;
                rSelNext  = fifoHead;
                rPendNext = fifoHead;
                stateNext = SEL_FIRE;
            end else begin
                rPendNext = '0;
                stateNext = SEL_IDLE;
            end
        end
`ifdef SEL_TIMEOUT_EN
        wdogNext = wdog;
        if (stateNext == SEL_FIRE)
            wdogNext = '0;
        else if (state == SEL_WAIT && stateNext == SEL_WAIT)
            wdogNext = wdog + WdW'(1);
`endif
    end

    // Output values for the coming cycle, aligned with the registered state.
    always_comb begin
        freeNext_c    = accept_c;
        driveNext_c   = (stateNext == SEL_FIRE) ? rSelNext : '0;
        countNext_c   = fifoCount + CntW'(pushTok_c) - CntW'(pop_c);
        busyNext_c    = (stateNext != SEL_IDLE) | (countNext_c != '0);
        errNext_c     = o_err_overflow | drop_c;
`ifdef SEL_TIMEOUT_EN
        timeoutNext_c = o_timeout | abandon_c;
`else
        timeoutNext_c = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_free         <= 1'b0;
            o_driveNext    <= '0;
            o_busy         <= 1'b0;
            o_err_overflow <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            o_free         <= freeNext_c;
            o_driveNext    <= driveNext_c;
            o_busy         <= busyNext_c;
            o_err_overflow <= errNext_c;
            o_timeout      <= timeoutNext_c;
        end
    end

endmodule
